leg_solver: RTL and testbench
=============================

LEG_SOLVER -- requirements
Module: leg_solver

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port ena  input  1  global enable; low freezes all state and outputs.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE with ena high.
REQ-005 SHALL have port r_in  input  8  hypotenuse magnitude, unsigned.
REQ-006 SHALL have port x_in  input  8  known leg, unsigned.
REQ-007 SHALL have port y_out  output  8  unknown leg result, unsigned, registered.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking y_out/err valid.
REQ-010 SHALL have port err  output  1  set when captured x_in > r_in, registered with done.

Function
REQ-011 SHALL compute y = floor(sqrt(r*r - x*x)), using a 16-bit difference and an 8-bit result.
REQ-012 SHALL implement states IDLE, SQUARE, DIFF, ITER, DONE; all transitions occur only on edges where ena is high.
REQ-013 IDLE: start high SHALL latch r_in/x_in and go to SQUARE; start low SHALL stay in IDLE.
REQ-014 SQUARE SHALL register r*r and x*x as 16-bit values, then go to DIFF (1 cycle).
REQ-015 DIFF SHALL register diff = r*r - x*x when x <= r, else diff = 0 with an internal error flag set. It SHALL clear the result, set the trial bit to 0x80, and go to ITER (1 cycle).
REQ-016 ITER SHALL perform one restoring step per cycle:
- if (result|bit)^2 <= diff, result <= result|bit;
- bit <= bit>>1.
After the step with bit = 0x01, it SHALL go to DONE (exactly 8 cycles).
REQ-017 DONE SHALL load y_out and err, pulse done high for exactly one cycle, and return to IDLE.
REQ-018 Latency: done SHALL be high during the cycle after the 12th enabled edge, counting the start-sampling edge as edge 1. Latency SHALL be fixed and independent of the operand values, including the error case.
REQ-019 y_out and err SHALL hold their values until the next DONE.
REQ-020 start outside IDLE SHALL be ignored and not queued. A start asserted during the done cycle SHALL be accepted, so back-to-back throughput is one result per 12 cycles.
REQ-021 ena low mid-operation SHALL stall the block without losing state. If ena falls while done is high, done SHALL stay high until the next enabled edge.
REQ-022 x = r SHALL give y_out = 0 with err = 0. x > r SHALL give y_out = 0 with err = 1.

Reset
REQ-023 rst_n low SHALL immediately force state = IDLE, y_out = 0, busy = 0, done = 0, err = 0, and clear all internal registers.
REQ-024 Reset asserted mid-operation SHALL abort the computation with no done pulse. After release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-025 Macro LEG_SOLVER_ROUND_EN defined: in DONE, the block SHALL load result+1 when diff - result^2 > result (round to nearest), otherwise result. Overflow is impossible because max diff = 65025. Latency SHALL be unchanged.
REQ-026 Macro LEG_SOLVER_ROUND_EN undefined: y_out SHALL be the floor result and no rounding logic SHALL be present.

Verification
REQ-027 r=5, x=3, start pulse -> done in the 12th cycle with y_out=4, err=0; busy high for 11 cycles.
REQ-028 r=255, x=0 -> y_out=255, err=0. r=200, x=200 -> y_out=0, err=0.
REQ-029 r=3, x=5 -> y_out=0, err=1, with the same 12-cycle latency.
REQ-030 r=12, x=5 (diff 119) -> y_out=10 without LEG_SOLVER_ROUND_EN; y_out=11 with it.
REQ-031 Start r=5, x=3; hold ena low for 4 cycles during ITER -> done 4 cycles later than nominal with y_out=4. Extra start pulses while busy -> ignored.
REQ-032 Start r=10, x=6; assert rst_n low in the 5th cycle -> all outputs 0 immediately, no done. Then start r=10, x=6 -> y_out=8.

Source files
------------

// File: rtl/leg_solver.sv
// Unknown right-triangle leg: y = floor(sqrt(r*r - x*x)) via an 8-step restoring square root.
// Optional round-to-nearest on the final result when LEG_SOLVER_ROUND_EN is defined.
module leg_solver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] r_in,
  input  logic [7:0] x_in,
  output logic [7:0] y_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQUARE = 3'd1,
    DIFF   = 3'd2,
    ITER   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  r_reg, x_reg;
  logic [15:0] r_sq_reg, x_sq_reg, diff_reg;
  logic [7:0]  result_reg, bit_reg;
  logic        err_flag_reg;
  logic [7:0]  y_out_reg;
  logic        err_reg, done_reg;

  logic [7:0]  trial;
  logic [15:0] trial_sq;
  logic [7:0]  y_final;

  // Candidate for this restoring step: current result with the trial bit set.
  always_comb begin
    trial    = result_reg | bit_reg;
    trial_sq = {8'h00, trial} * {8'h00, trial};
  end

`ifdef LEG_SOLVER_ROUND_EN
  logic [15:0] result_sq, remainder;

  // Round up when the remainder exceeds result, i.e. sqrt(diff) >= result + 0.5.
  always_comb begin
    result_sq = {8'h00, result_reg} * {8'h00, result_reg};
    remainder = diff_reg - result_sq;
    y_final   = (remainder > {8'h00, result_reg}) ? result_reg + 8'd1 : result_reg;
  end
`else
  assign y_final = result_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else if (ena) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SQUARE;
      SQUARE:  state_next = DIFF;
      DIFF:    state_next = ITER;
      ITER:    if (bit_reg == 8'h01) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg        <= 8'h00;
      x_reg        <= 8'h00;
      r_sq_reg     <= 16'h0000;
      x_sq_reg     <= 16'h0000;
      diff_reg     <= 16'h0000;
      result_reg   <= 8'h00;
      bit_reg      <= 8'h00;
      err_flag_reg <= 1'b0;
      y_out_reg    <= 8'h00;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else if (ena) begin
      // done is a one-enabled-cycle pulse; it holds while ena is low.
      done_reg <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            r_reg <= r_in;
            x_reg <= x_in;
          end
        end
        SQUARE: begin
          r_sq_reg <= {8'h00, r_reg} * {8'h00, r_reg};
          x_sq_reg <= {8'h00, x_reg} * {8'h00, x_reg};
        end
        DIFF: begin
          if (x_reg <= r_reg) begin
            diff_reg     <= r_sq_reg - x_sq_reg;
            err_flag_reg <= 1'b0;
          end else begin
            diff_reg     <= 16'h0000;
            err_flag_reg <= 1'b1;
          end
          result_reg <= 8'h00;
          bit_reg    <= 8'h80;
        end
        ITER: begin
          if (trial_sq <= diff_reg) result_reg <= trial;
          bit_reg <= bit_reg >> 1;
        end
        DONE: begin
          y_out_reg <= y_final;
          err_reg   <= err_flag_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;
  assign y_out = y_out_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_leg_solver.sv
// Randomized self-checking bench for leg_solver against an arithmetic reference model.
module tb_leg_solver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] r_in;
  logic [7:0] x_in;
  logic [7:0] y_out;
  logic       busy;
  logic       done;
  logic       err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  leg_solver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .r_in  (r_in),
    .x_in  (x_in),
    .y_out (y_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Largest y with y*y <= r*r - x*x, or 0 when x > r; optionally rounded to nearest.
  function automatic int ref_y(input int r, input int x);
    int d, y;
    if (x > r) return 0;
    d = r * r - x * x;
    y = 0;
    while ((y + 1) * (y + 1) <= d) y++;
`ifdef LEG_SOLVER_ROUND_EN
    if (d - y * y > y) y++;
`endif
    return y;
  endfunction

  // Called between edges; issues start, then follows the op until done.
  task automatic run_op(input int r, input int x, input string tag);
    int n, busy_n, ey, ee;
    ey = ref_y(r, x);
    ee = (x > r) ? 1 : 0;
    start = 1'b1;
    r_in  = 8'(r);
    x_in  = 8'(x);
    @(posedge clk); #1;
    start = 1'b0;
    r_in  = 8'($urandom);
    x_in  = 8'($urandom);
    check({tag, "_busy_on"}, int'(busy), 1);
    check({tag, "_done_low"}, int'(done), 0);
    busy_n = 1;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
    end
    check({tag, "_latency"}, n, 11);
    check({tag, "_busy_cycles"}, busy_n, 11);
    check({tag, "_y"}, int'(y_out), ey);
    check({tag, "_err"}, int'(err), ee);
    $display("op %s r=%0d x=%0d y=%0d err=%0d lat=%0d", tag, r, x, y_out, err, n + 1);
  endtask

  initial begin
    int n, r, x;
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    r_in  = 8'h00;
    x_in  = 8'h00;
    #1;
    check("rst_y", int'(y_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);

    run_op(5, 3, "r5x3");
    @(posedge clk); #1;
    check("pulse_one_cycle", int'(done), 0);
    check("y_hold", int'(y_out), 4);
    run_op(255, 0, "r255x0");
    run_op(200, 200, "r200x200");
    run_op(12, 5, "r12x5");
    run_op(3, 5, "r3x5");

    // Stall mid-ITER while spamming start; starts while busy must be ignored.
    start = 1'b1; r_in = 8'd5; x_in = 8'd3;
    @(posedge clk); #1;
    r_in = 8'd9; x_in = 8'd1;
    repeat (4) @(posedge clk);
    #1 ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("stall_busy", int'(busy), 1);
      check("stall_done", int'(done), 0);
    end
    ena = 1'b1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_remaining", n, 7);
    check("stall_y", int'(y_out), 4);
    $display("op stall r=5 x=3 y=%0d err=%0d", y_out, err);
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("done_held_ena_low", int'(done), 1);
    ena = 1'b1;
    @(posedge clk); #1;
    check("done_cleared", int'(done), 0);
    check("no_queued_start", int'(busy), 0);

    // Reset in the 5th cycle of an operation aborts it with no done pulse.
    start = 1'b1; r_in = 8'd10; x_in = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_y", int'(y_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_err", int'(err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    check("abort_no_activity", n, 0);
    run_op(10, 6, "r10x6");

    // Back-to-back random ops: each start lands in the previous done cycle.
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 255));
      x = ($urandom_range(0, 7) == 0) ? r : int'($urandom_range(0, 255));
      run_op(r, x, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
